// File: rtl/scr1_imem_arb.sv
// Two-master arbiter onto a single imem read port: round-robin or fixed priority,
// grant held while a request waits for acceptance, in-order response routing by ID FIFO.
module scr1_imem_arb #(
   parameter int OUTSTANDING = 2,
   parameter bit RR_EN       = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   output logic        m0_req_ack,
   output logic [31:0] m0_rdata,
   output logic [1:0]  m0_resp,

   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   output logic        m1_req_ack,
   output logic [31:0] m1_rdata,
   output logic [1:0]  m1_resp,

   output logic        imem_req,
   output logic        imem_cmd,
   output logic [31:0] imem_addr,
   input  logic        imem_req_ack,
   input  logic [31:0] imem_rdata,
   input  logic [1:0]  imem_resp,

   output logic        err_unexp_resp
);

   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CW = $clog2(OUTSTANDING + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(OUTSTANDING);
   localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);

   // Handshake: a transfer is accepted in any cycle with imem_req and imem_req_ack both high;
   // the requester keeps mN_req and mN_addr stable until its mN_req_ack.

   logic                   lock_vld_q;
   logic                   lock_id_q;
   logic                   prio_q;
   logic                   err_q;
   logic [OUTSTANDING-1:0] fifo_q;
   logic [PW-1:0]          wr_ptr_q;
   logic [PW-1:0]          rd_ptr_q;
   logic [CW-1:0]          cnt_q;

   logic arb_id;
   logic grant;
   logic grant_req;
   logic accept;
   logic fifo_empty;
   logic fifo_full;
   logic resp_vld;
   logic pop;
   logic head_id;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      arb_id = 1'b0;
      if (m0_req && m1_req) begin
         arb_id = RR_EN ? prio_q : 1'b0;
      end else if (m1_req) begin
         arb_id = 1'b1;
      end
   end

   // A waiting, un-acked request keeps its grant so the address cannot change under it.
   assign grant      = lock_vld_q ? lock_id_q : arb_id;
   assign grant_req  = grant ? m1_req : m0_req;
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == CNT_MAX);

   assign imem_req   = rst_n & grant_req & ~fifo_full;
   assign imem_cmd   = 1'b0;
   assign imem_addr  = grant ? m1_addr : m0_addr;
   assign accept     = imem_req & imem_req_ack;
   assign m0_req_ack = accept & ~grant;
   assign m1_req_ack = accept & grant;

   assign resp_vld = (imem_resp != 2'b00);
   assign pop      = resp_vld & ~fifo_empty;
   assign head_id  = fifo_q[rd_ptr_q];

   always_comb begin
      m0_resp  = 2'b00;
      m1_resp  = 2'b00;
      m0_rdata = '0;
      m1_rdata = '0;
      if (!fifo_empty) begin
         if (head_id) begin
            m1_resp  = imem_resp;
            m1_rdata = imem_rdata;
         end else begin
            m0_resp  = imem_resp;
            m0_rdata = imem_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_vld_q <= 1'b0;
         lock_id_q  <= 1'b0;
         prio_q     <= 1'b0;
         err_q      <= 1'b0;
         fifo_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         lock_vld_q <= imem_req & ~imem_req_ack;
         lock_id_q  <= grant;
         if (accept) begin
            prio_q           <= ~grant;
            fifo_q[wr_ptr_q] <= grant;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({accept, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (resp_vld && fifo_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_unexp_resp = err_q;

endmodule

// File: doc/scr1_imem_arb.md
SCR1_IMEM_ARB -- requirements
Module: scr1_imem_arb

Interface
REQ-001 The block SHALL have parameter OUTSTANDING, default 2, giving the maximum number of accepted imem requests still awaiting a response (legal range 1..4).
REQ-002 The block SHALL have parameter RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with m0 highest.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports m0_req/m1_req, input, 1 each, request valid from requester N (m0 = core IFU, m1 = debug program-buffer fetcher).
REQ-006 The block SHALL have ports m0_addr/m1_addr, input, 32 each, read address; held stable by the requester until accepted.
REQ-007 The block SHALL have ports m0_req_ack/m1_req_ack, output, 1 each, request accepted this cycle.
REQ-008 The block SHALL have ports m0_rdata/m1_rdata, output, 32 each, response data.
REQ-009 The block SHALL have ports m0_resp/m1_resp, output, 2 each, response code (00 idle, 01 OK, 10 error).
REQ-010 The block SHALL have ports imem_req (output, 1), imem_cmd (output, 1, always 0 = read), imem_addr (output, 32), imem_req_ack (input, 1), imem_rdata (input, 32) and imem_resp (input, 2), the shared downstream imem port.
REQ-011 The block SHALL have port err_unexp_resp, output, 1, sticky flag for a non-idle imem_resp with no outstanding request.

Function
REQ-012 The block SHALL accept a transfer in any cycle where imem_req and imem_req_ack are both 1; mN_req_ack SHALL equal imem_req_ack AND (grant == N) AND imem_req.
REQ-013 The block SHALL drive imem_req = (granted mN_req) AND (outstanding count < OUTSTANDING), and imem_addr = granted mN_addr; the request path is combinational, with zero added latency.
REQ-014 Arbitration: if exactly one master requests, it is granted; if both request, the granted master is the priority pointer (RR_EN=1) or m0 (RR_EN=0).
REQ-015 Grant lock: once imem_req is 1 and not acked, the grant SHALL be registered and held, with no switch, until the accepting cycle.
REQ-016 The priority pointer SHALL move to the other master on each accepted transfer; it SHALL NOT move on non-accepted cycles.
REQ-017 An in-order ID FIFO of depth OUTSTANDING SHALL push the granted master ID on each accept and pop on each cycle with imem_resp != 00 while not empty.
REQ-018 The response SHALL be routed combinationally to the FIFO-head master: mN_resp = imem_resp and mN_rdata = imem_rdata for the head ID; the other master sees resp 00 and rdata 0.
REQ-019 An error response (10) SHALL pop and route exactly like 01.
REQ-020 A simultaneous push and pop SHALL leave the count unchanged and preserve order; when the FIFO is full, a same-cycle pop SHALL NOT enable a new accept (no bypass).
REQ-021 A non-idle imem_resp with the FIFO empty SHALL be dropped (both mN_resp = 00) and SHALL set err_unexp_resp until reset.
REQ-022 FIFO pointers SHALL wrap modulo OUTSTANDING; the count width SHALL hold 0..OUTSTANDING without overflow.

Reset
REQ-023 While rst_n = 0, the block SHALL hold: FIFO empty, grant lock cleared, priority pointer = m0, err_unexp_resp = 0, imem_req = 0, all mN_req_ack = 0, all mN_resp = 00.
REQ-024 Reset asserted mid-transfer SHALL discard all outstanding IDs; responses arriving after reset release SHALL be treated per REQ-021.

Verification
REQ-025 Both masters request continuously, imem_req_ack = 1, single-cycle responses -> accepts alternate m0, m1, m0, m1; each response reaches only the issuing master.
REQ-026 RR_EN=0, both request -> only m0 is acked while m0_req = 1; m1 is acked in the first cycle m0_req = 0.
REQ-027 m1 granted with imem_req_ack = 0 for 3 cycles, m0 raises its request in cycle 2 -> imem_addr stays m1_addr and the grant stays with m1 until the ack; m0 is served next.
REQ-028 OUTSTANDING=2, responses withheld -> after 2 accepts imem_req = 0; a response of 10 then pops the FIFO, the error reaches the first requester, and imem_req reasserts next cycle.
REQ-029 imem_resp = 01 with no outstanding request -> both mN_resp = 00 and err_unexp_resp = 1 until rst_n = 0.
REQ-030 rst_n pulsed low with 2 requests outstanding -> all outputs take their reset values immediately and the FIFO count is 0 after release.
